// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one resource.
// The owner keeps the grant until done, request drop or hold-limit expiry; one idle cycle separates owners.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    state_t           state_q;
    logic [2:0]       ptr_q;
    logic [2:0]       owner_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [7:0]       gnt_q;
    logic [2:0]       gnt_idx_q;
    logic             gnt_valid_q;
    logic             preempt_q;

    logic       sel_found;
    logic [2:0] sel_idx;
    logic [2:0] cand;
    logic       hold_hit;
    logic       owner_req;
    logic       release_now;
    logic       timeout_only;

    // First requester at or after ptr_q, wrapping modulo 8.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        hold_hit     = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(HOLD_LAST));
        owner_req    = req[owner_q];
        release_now  = done || !owner_req || hold_hit;
        timeout_only = hold_hit && !done && owner_req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    preempt_q <= 1'b0;
                    if (sel_found) begin
                        state_q     <= GRANT;
                        owner_q     <= sel_idx;
                        gnt_q       <= 8'b1 << sel_idx;
                        gnt_idx_q   <= sel_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // Just-served index becomes lowest priority on the next scan.
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_idx_q   <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= owner_q + 3'd1;
                        hold_cnt_q  <= '0;
                        preempt_q   <= timeout_only;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + CNT_W'(1);
                        preempt_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with hold limit 4: expected outputs queued per edge,
// compared on the following falling edge.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // packed as {gnt, gnt_idx, gnt_valid, preempt}
  logic [12:0] exp_q[$];
  string       tag_q[$];

  localparam logic [12:0] IDLE_E = 13'h0000;
  localparam logic [12:0] PRE_E  = 13'h0001;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] g(input int i);
    logic [7:0] oh;
    oh = 8'h01 << i;
    return {oh, 3'(i), 1'b1, 1'b0};
  endfunction

  // driver: apply inputs for one edge and queue what must be visible after it
  task automatic step(input logic [7:0] r, input logic d, input logic rn,
                      input logic [12:0] e, input string tag);
    @(negedge clk);
    req   = r;
    done  = d;
    rst_n = rn;
    @(posedge clk);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [12:0] e;
    logic [12:0] obs;
    string       t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {gnt, gnt_idx, gnt_valid, preempt};
      n_checks++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed gnt=%h idx=%0d valid=%b preempt=%b, expected gnt=%h idx=%0d valid=%b preempt=%b",
               t, obs[12:5], obs[4:2], obs[1], obs[0], e[12:5], e[4:2], e[1], e[0]);
      end
      n_checks++;
      assert (!(gnt_valid === 1'b1 && preempt === 1'b1)) else begin
        n_fail++;
        $error("FAIL %s_excl: observed valid=%b preempt=%b, expected not both 1", t, gnt_valid, preempt);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    repeat (2) step(8'h00, 1'b0, 1'b0, IDLE_E, "reset");

    // no requests: stays idle
    repeat (5) step(8'h00, 1'b0, 1'b1, IDLE_E, "no_req");

    // two requesters, owner releases with done after 3 grant cycles
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (k % 2 == 0) ? 0 : 7;
      step(8'h81, 1'b0, 1'b1, g(idx), "alt_grant");
      step(8'h81, 1'b0, 1'b1, g(idx), "alt_hold");
      step(8'h81, 1'b0, 1'b1, g(idx), "alt_hold");
      step(8'h81, 1'b1, 1'b1, IDLE_E, "alt_done_gap");
    end

    // sole requester hits the hold limit and is regranted after the gap
    step(8'h04, 1'b0, 1'b1, g(2), "solo_grant");
    repeat (3) step(8'h04, 1'b0, 1'b1, g(2), "solo_hold");
    step(8'h04, 1'b0, 1'b1, PRE_E, "solo_preempt");
    step(8'h04, 1'b0, 1'b1, g(2), "solo_regrant");
    step(8'h00, 1'b0, 1'b1, IDLE_E, "solo_drop");

    // two requesters alternate through preemption, pointer wraps
    step(8'h24, 1'b0, 1'b0, IDLE_E, "rst_mid");
    step(8'h24, 1'b0, 1'b1, g(2), "pair_grant2");
    repeat (3) step(8'h24, 1'b0, 1'b1, g(2), "pair_hold2");
    step(8'h24, 1'b0, 1'b1, PRE_E, "pair_pre2");
    step(8'h24, 1'b0, 1'b1, g(5), "pair_grant5");
    repeat (3) step(8'h24, 1'b0, 1'b1, g(5), "pair_hold5");
    step(8'h24, 1'b0, 1'b1, PRE_E, "pair_pre5");
    step(8'h24, 1'b0, 1'b1, g(2), "pair_wrap2");
    step(8'h00, 1'b0, 1'b1, IDLE_E, "pair_drop");

    // owner 3 drops its request exactly at the limit; others' requests ignored
    step(8'h08, 1'b0, 1'b1, g(3), "drop_grant");
    step(8'hF8, 1'b0, 1'b1, g(3), "drop_ign_others");
    step(8'h18, 1'b0, 1'b1, g(3), "drop_ign_others");
    step(8'h08, 1'b0, 1'b1, g(3), "drop_hold");
    step(8'h00, 1'b0, 1'b1, IDLE_E, "drop_at_limit");

    // done in IDLE ignored; done coinciding with limit is not a preempt
    step(8'h08, 1'b1, 1'b1, g(3), "done_idle_ign");
    repeat (3) step(8'h08, 1'b0, 1'b1, g(3), "done_hold");
    step(8'h08, 1'b1, 1'b1, IDLE_E, "done_at_limit");

    // reset while owner 6 is at its limit: no preempt, pointer back to 0
    step(8'h40, 1'b0, 1'b1, g(6), "rst_grant6");
    repeat (3) step(8'h40, 1'b0, 1'b1, g(6), "rst_hold6");
    step(8'h40, 1'b0, 1'b0, IDLE_E, "rst_in_grant");
    step(8'hFF, 1'b0, 1'b1, g(0), "rst_first_all");
    step(8'hFF, 1'b1, 1'b1, IDLE_E, "all_done0");
    step(8'hFF, 1'b0, 1'b1, g(1), "all_next1");
    step(8'h00, 1'b0, 1'b1, IDLE_E, "all_drop");

    @(negedge clk);
    #1;
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
